// File: rtl/phimap_pkg.sv
// phimap_pkg: shared constants, FSM encoding and helpers for the trig scheduler.
//   PI_Q12    - pi in Q3.12, multiplier for the harmonic step
//   PI_Q15    - pi in Q.15 radians, fold threshold
//   TWOPI_Q15 - 2*pi in Q.15 radians, fold correction
//   S_*       - scheduler FSM states
//   nharm()   - number of harmonics for an expansion order
package phimap_pkg;
    localparam logic [16:0] PI_Q12    = 17'h3244;
    localparam int          PI_Q15    = 'h19220;
    localparam int          TWOPI_Q15 = 'h3243F;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MUL   = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    function automatic int nharm(input int q_ord);
        return (q_ord - 1) / 2;
    endfunction
endpackage

// File: rtl/phimap_angle_gen.sv
// phimap_angle_gen: harmonic angle accumulator for phimap_trig_scheduler.
//   clk, reset - clock, asynchronous active-low reset
//   load       - capture step = round(pi*x) and set theta = step
//   advance    - theta <= theta + step
//   x          - sample, Q1.15
//   theta      - current angle, Q.15 radians, ANGLE_W signed
//   PHIMAP_ANGLE_WRAP_EN defined: every angle is folded into [-pi, pi).
module phimap_angle_gen
    import phimap_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int ANGLE_W = WIDTH + 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               advance,
    input  logic [WIDTH-1:0]   x,
    output logic [ANGLE_W-1:0] theta
);
    localparam int PW = WIDTH + 18;
    logic signed [PW-1:0]      prod;
    logic signed [ANGLE_W-1:0] step, acc, step_c, load_c, next_c;

`ifdef PHIMAP_ANGLE_WRAP_EN
    localparam logic signed [ANGLE_W-1:0] PI_A  = ANGLE_W'(PI_Q15);
    localparam logic signed [ANGLE_W-1:0] TWO_A = ANGLE_W'(TWOPI_Q15);
    // |step| <= pi, so a single correction brings theta back into range
    function automatic logic signed [ANGLE_W-1:0] fold(input logic signed [ANGLE_W-1:0] a);
        return a >= PI_A ? a - TWO_A : a < -PI_A ? a + TWO_A : a;
    endfunction
`else
    function automatic logic signed [ANGLE_W-1:0] fold(input logic signed [ANGLE_W-1:0] a);
        return a;
    endfunction
`endif

    // Q1.15 * Q3.12 = Q.27; add half an LSB at bit 11, drop 12 bits to reach Q.15
    assign prod   = PW'($signed(x)) * PW'($signed({1'b0, PI_Q12})) + PW'(2048);
    assign step_c = ANGLE_W'(prod >>> 12);
    assign load_c = fold(step_c);
    assign next_c = fold(acc + step);
    assign theta  = acc;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            step <= '0;
            acc  <= '0;
        end else if (load) begin
            step <= step_c;
            acc  <= load_c;
        end else if (advance)
            acc <= next_c;
endmodule

// File: rtl/phimap_trig_scheduler.sv
// phimap_trig_scheduler: issues k*pi*x (k=1..H) to one shared sin/cos unit and packs Phi.
//   clk, reset            - clock, asynchronous active-low reset
//   x_in/in_valid/in_ready - input sample handshake
//   trig_theta/trig_vld   - angle issued to the shared sin/cos unit
//   trig_sin/trig_cos/trig_rvld - results returned L_TRIG cycles after issue
//   phi_out/out_valid/out_ready - packed Phi {[0]=x, [2k-1]=sin, [2k]=cos}, held until accepted
//   PHIMAP_ANGLE_WRAP_EN defined: issued angles are folded into [-pi, pi).
module phimap_trig_scheduler
    import phimap_pkg::*;
#(
    parameter int Q_ORD   = 7,
    parameter int WIDTH   = 16,
    parameter int ANGLE_W = WIDTH + 3,
    parameter int L_TRIG  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       x_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [ANGLE_W-1:0]     trig_theta,
    output logic                   trig_vld,
    input  logic [WIDTH-1:0]       trig_sin,
    input  logic [WIDTH-1:0]       trig_cos,
    input  logic                   trig_rvld,
    output logic [Q_ORD*WIDTH-1:0] phi_out,
    output logic                   out_valid,
    input  logic                   out_ready
);
    localparam int H  = nharm(Q_ORD);
    localparam int KW = $clog2(H + 1);

    logic [2:0]             state;
    logic [KW-1:0]          k, r;
    logic [Q_ORD*WIDTH-1:0] phi;
    logic [ANGLE_W-1:0]     theta;
    logic                   issue, ret;

    phimap_angle_gen #(.WIDTH(WIDTH), .ANGLE_W(ANGLE_W)) u_angle (
        .clk    (clk),
        .reset  (reset),
        .load   (state == S_MUL),
        .advance(issue),
        .x      (phi[WIDTH-1:0]),
        .theta  (theta)
    );

    assign issue      = state == S_ISSUE;
    // returns can only land inside ISSUE when the unit is shorter than the burst
    assign ret        = trig_rvld && (state == S_DRAIN || (issue && L_TRIG < H));
    assign in_ready   = reset && state == S_IDLE;
    assign trig_vld   = issue;
    assign trig_theta = issue ? theta : '0;
    assign out_valid  = state == S_HOLD;
    assign phi_out    = phi;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= S_IDLE;
            k     <= '0;
            r     <= '0;
            phi   <= '0;
        end else begin
            case (state)
                S_IDLE:  if (in_valid) begin
                    phi[WIDTH-1:0] <= x_in;
                    state          <= S_MUL;
                end
                S_MUL:   begin
                    k     <= KW'(1);
                    r     <= KW'(1);
                    state <= S_ISSUE;
                end
                S_ISSUE: begin
                    k <= k + KW'(1);
                    if (k == KW'(H)) state <= S_DRAIN;
                end
                S_DRAIN: if (ret && r == KW'(H)) state <= S_HOLD;
                S_HOLD:  if (out_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            if (ret) begin
                phi[(2 * int'(r) - 1) * WIDTH +: WIDTH] <= trig_sin;
                phi[2 * int'(r) * WIDTH +: WIDTH]       <= trig_cos;
                r                                       <= r + KW'(1);
            end
        end
endmodule

// File: tb/tb_phimap_trig_scheduler.sv
// tb_phimap_trig_scheduler: vector table, corner sequences and random samples vs a reference model.
module tb_phimap_trig_scheduler;
    localparam int Q = 7, W = 16, AW = 19, L = 4, H = 3;
    localparam int PI = 'h19220, TWO = 'h3243F;
`ifdef PHIMAP_ANGLE_WRAP_EN
    localparam int TOL = 2;
`else
    localparam int TOL = 0;
`endif

    logic           clk = 0;
    logic           reset;
    logic [W-1:0]   x_in;
    logic           in_valid, in_ready;
    logic [AW-1:0]  trig_theta;
    logic           trig_vld;
    logic [W-1:0]   trig_sin, trig_cos;
    logic           trig_rvld;
    logic [Q*W-1:0] phi_out;
    logic           out_valid, out_ready;

    int             total, bad;
    int             iss_th [8];
    int             iss_cyc [8];
    int             n_iss, ov_cyc;
    logic [Q*W-1:0] phi_cap;
    bit             busy_rdy;
    longint         acc_t;

    typedef struct {
        logic [W-1:0] x;
        int t1, t2, t3;
        int s1, c1;
        int hold;
    } vec_t;
    vec_t tbl [4];

    phimap_trig_scheduler dut (
        .clk(clk), .reset(reset), .x_in(x_in), .in_valid(in_valid), .in_ready(in_ready),
        .trig_theta(trig_theta), .trig_vld(trig_vld), .trig_sin(trig_sin), .trig_cos(trig_cos),
        .trig_rvld(trig_rvld), .phi_out(phi_out), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic int qtrig(int a, bit c);
        real v = (c ? $cos(a / 32768.0) : $sin(a / 32768.0)) * 32767.0;
        return int'(v);
    endfunction

    // k-th harmonic angle straight from theta_k = k*round(pi*x), then range reduced
    function automatic int model_theta(logic [W-1:0] x, int k);
        int step = (12868 * int'($signed(x)) + 2048) >>> 12;
        int v = k * step;
`ifdef PHIMAP_ANGLE_WRAP_EN
        int m = (v + PI) % TWO;
        if (m < 0) m += TWO;
        return m - PI;
`else
        int m = v & 'h7FFFF;
        return m >= 'h40000 ? m - 'h80000 : m;
`endif
    endfunction

    function automatic int el(logic [Q*W-1:0] p, int i);
        return int'($signed(p[i*W +: W]));
    endfunction

    // shared sin/cos unit: ideal rounded results delayed L cycles
    bit           pv [L];
    logic [W-1:0] ps [L];
    logic [W-1:0] pc [L];
    always @(posedge clk) begin
        pv[0] <= trig_vld;
        ps[0] <= 16'(qtrig(int'($signed(trig_theta)), 0));
        pc[0] <= 16'(qtrig(int'($signed(trig_theta)), 1));
        for (int i = 1; i < L; i++) begin
            pv[i] <= pv[i-1];
            ps[i] <= ps[i-1];
            pc[i] <= pc[i-1];
        end
    end
    assign trig_rvld = pv[L-1];
    assign trig_sin  = ps[L-1];
    assign trig_cos  = pc[L-1];

    task automatic chk(string nm, int act, int exp, int tol = 0);
        total++;
        if (act - exp > tol || exp - act > tol) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic txn(input logic [W-1:0] x, input int hold);
        int c;
        bit stable;
        out_ready = (hold == 0);
        x_in      = x;
        in_valid  = 1;
        c = 0;
        while (!in_ready && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("accept_ready", int'(in_ready), 1);
        @(posedge clk);
        acc_t = $time;
        #1 in_valid = 0;
        n_iss = 0; ov_cyc = -1; busy_rdy = 0;
        for (c = 1; c <= 40 && ov_cyc < 0; c++) begin
            @(negedge clk);
            if (in_ready) busy_rdy = 1;
            if (trig_vld && n_iss < 8) begin
                iss_th[n_iss]  = int'($signed(trig_theta));
                iss_cyc[n_iss] = c;
                n_iss++;
            end
            if (out_valid) begin
                ov_cyc  = c;
                phi_cap = phi_out;
            end
        end
        chk("out_valid_seen", int'(ov_cyc > 0), 1);
        stable = 1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!out_valid || phi_out !== phi_cap || in_ready) stable = 0;
        end
        if (hold > 0) chk("hold_stable", int'(stable), 1);
        out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        chk("idle_after_accept", int'({in_ready, out_valid}), 2);
    endtask

    task automatic verify(input logic [W-1:0] x);
        chk("latency", ov_cyc, H + 2 + L);
        chk("issue_count", n_iss, H);
        chk("busy_in_ready", int'(busy_rdy), 0);
        chk("phi0", el(phi_cap, 0), int'($signed(x)));
        for (int k = 1; k <= H; k++) begin
            int e = model_theta(x, k);
`ifdef PHIMAP_ANGLE_WRAP_EN
            if ((iss_th[k-1] - e == TWO || e - iss_th[k-1] == TWO) && iss_th[k-1] >= -PI && iss_th[k-1] < PI)
                e = iss_th[k-1];
`endif
            chk($sformatf("theta%0d x=%h", k, x), iss_th[k-1], e);
            chk($sformatf("issue_cyc%0d", k), iss_cyc[k-1], k + 1);
            chk($sformatf("sin%0d x=%h", k, x), el(phi_cap, 2*k-1), qtrig(model_theta(x, k), 0), TOL);
            chk($sformatf("cos%0d x=%h", k, x), el(phi_cap, 2*k), qtrig(model_theta(x, k), 1), TOL);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [Q*W-1:0] pa;
        longint ta;
        total = 0; bad = 0;
        reset = 0; in_valid = 0; x_in = '0; out_ready = 0;
        tbl[0] = '{16'h0000, 0, 0, 0, 0, 32767, 0};
`ifdef PHIMAP_ANGLE_WRAP_EN
        tbl[1] = '{16'h4000, 51472, -102943, -51471, 32767, 0, 0};
        tbl[2] = '{16'hC000, -51472, -102944, 51471, -32767, 0, 20};
        tbl[3] = '{16'h8000, -102944, -1, 102942, 0, -32767, 1};
`else
        tbl[1] = '{16'h4000, 51472, 102944, 154416, 32767, 0, 0};
        tbl[2] = '{16'hC000, -51472, -102944, -154416, -32767, 0, 20};
        tbl[3] = '{16'h8000, -102944, -205888, 215456, 0, -32767, 1};
`endif
        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_trig_vld", int'(trig_vld), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_theta", int'(trig_theta), 0);
        chk("rst_phi_nonzero", int'(phi_out != '0), 0);
        reset = 1;
        #1 chk("ready_after_reset", int'(in_ready), 1);

        for (int i = 0; i < 4; i++) begin
            txn(tbl[i].x, tbl[i].hold);
            verify(tbl[i].x);
            chk($sformatf("tbl%0d_t1", i), iss_th[0], tbl[i].t1);
            chk($sformatf("tbl%0d_t2", i), iss_th[1], tbl[i].t2);
            chk($sformatf("tbl%0d_t3", i), iss_th[2], tbl[i].t3);
            chk($sformatf("tbl%0d_phi1", i), el(phi_cap, 1), tbl[i].s1, 1);
            chk($sformatf("tbl%0d_phi2", i), el(phi_cap, 2), tbl[i].c1, 1);
        end

        // reset in the middle of a transaction, stale returns arrive in IDLE/MUL
        x_in = 16'h3000; in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        repeat (5) @(negedge clk);
        reset = 0;
        #1;
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_trig_vld", int'(trig_vld), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_theta", int'(trig_theta), 0);
        chk("midrst_phi_nonzero", int'(phi_out != '0), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        txn(16'h1234, 0);
        verify(16'h1234);

        // back-to-back: odd sin, even cos, full-rate throughput
        txn(16'h2000, 0);
        verify(16'h2000);
        pa = phi_cap; ta = acc_t;
        txn(16'hE000, 0);
        verify(16'hE000);
        chk("b2b_period", int'((acc_t - ta) / 10), H + 3 + L);
        for (int k = 1; k <= H; k++) begin
            chk($sformatf("b2b_sin%0d", k), el(phi_cap, 2*k-1), -el(pa, 2*k-1));
            chk($sformatf("b2b_cos%0d", k), el(phi_cap, 2*k), el(pa, 2*k));
        end

        repeat (12) begin
            logic [W-1:0] rx;
            rx = W'($urandom);
            txn(rx, int'($urandom_range(0, 3)));
            verify(rx);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
